// File: rtl/serial_adder_pw.sv
// Multi-cycle ripple adder/subtractor: DIGIT bits per clock through a full-adder
// chain with a registered carry; reports sum, carry-out and signed overflow.
module serial_adder_pw #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   chain_c;
  logic [DIGIT-1:0] digit_s;

  // DIGIT-bit ripple chain fed by the registered carry
  always_comb begin
    chain_c    = '0;
    digit_s    = '0;
    chain_c[0] = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      digit_s[i]   = a_q[i] ^ b_q[i] ^ chain_c[i];
      chain_c[i+1] = (a_q[i] & b_q[i]) | (chain_c[i] & (a_q[i] ^ b_q[i]));
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    start_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          // Subtraction as a + ~b + ~cin gives a - b - cin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = chain_c[DIGIT];
        sum_d   = (sum_q >> DIGIT) | (WIDTH'(digit_s) << (WIDTH - DIGIT));
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d  = chain_c[DIGIT];
          ovf_d   = chain_c[DIGIT] ^ chain_c[DIGIT-1];
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_pw.sv
// Directed bench for serial_adder_pw with DIGIT = 1, 4 and 8 instances side by side.
module tb_serial_adder_pw;

  logic       clk = 1'b0;
  logic       rst;
  logic       sub_i;
  logic [7:0] a_i, b_i;
  logic       cin_i;
  logic       sv [3];
  logic       ready_w [3];
  logic [7:0] sum_w [3];
  logic       cout_w [3];
  logic       ovf_w [3];
  logic       busy_w [3];
  logic       done_w [3];

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  serial_adder_pw #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start_valid(sv[0]), .start_ready(ready_w[0]),
    .sub(sub_i), .a(a_i), .b(b_i), .cin(cin_i), .sum(sum_w[0]),
    .cout(cout_w[0]), .ovf(ovf_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  serial_adder_pw #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start_valid(sv[1]), .start_ready(ready_w[1]),
    .sub(sub_i), .a(a_i), .b(b_i), .cin(cin_i), .sum(sum_w[1]),
    .cout(cout_w[1]), .ovf(ovf_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  serial_adder_pw #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start_valid(sv[2]), .start_ready(ready_w[2]),
    .sub(sub_i), .a(a_i), .b(b_i), .cin(cin_i), .sum(sum_w[2]),
    .cout(cout_w[2]), .ovf(ovf_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full handshake on instance s (n digits), then check timing and result
  task automatic run_op(input int s, input int n, input logic sb, input logic [7:0] av,
                        input logic [7:0] bv, input logic ci, input logic [7:0] es,
                        input logic ec, input logic eo, input string tag);
    sub_i = sb; a_i = av; b_i = bv; cin_i = ci; sv[s] = 1'b1;
    check({tag, " ready_idle"}, 32'(ready_w[s]), 32'd1);
    tick();
    sv[s] = 1'b0;
    check({tag, " busy_run"}, 32'(busy_w[s]), 32'd1);
    for (int k = 1; k < n; k++) begin
      tick();
      check($sformatf("%s done_early%0d", tag, k), 32'(done_w[s]), 32'd0);
      check($sformatf("%s ready_run%0d", tag, k), 32'(ready_w[s]), 32'd0);
    end
    tick();
    check({tag, " done"}, 32'(done_w[s]), 32'd1);
    check({tag, " busy_done"}, 32'(busy_w[s]), 32'd0);
    check({tag, " ready_done"}, 32'(ready_w[s]), 32'd0);
    check({tag, " sum"}, 32'(sum_w[s]), 32'(es));
    check({tag, " cout"}, 32'(cout_w[s]), 32'(ec));
    check({tag, " ovf"}, 32'(ovf_w[s]), 32'(eo));
    tick();
    check({tag, " done_pulse"}, 32'(done_w[s]), 32'd0);
    check({tag, " ready_after"}, 32'(ready_w[s]), 32'd1);
    check({tag, " sum_hold"}, 32'(sum_w[s]), 32'(es));
    $display("op %s: a=%02h b=%02h cin=%0b sub=%0b -> sum=%02h cout=%0b ovf=%0b",
             tag, av, bv, ci, sb, sum_w[s], cout_w[s], ovf_w[s]);
  endtask

  initial begin
    rst = 1'b1; sub_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;
    for (int i = 0; i < 3; i++) sv[i] = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst sum%0d", i), 32'(sum_w[i]), 32'd0);
      check($sformatf("rst ready%0d", i), 32'(ready_w[i]), 32'd1);
      check($sformatf("rst busy%0d", i), 32'(busy_w[i]), 32'd0);
      check($sformatf("rst done%0d", i), 32'(done_w[i]), 32'd0);
    end
    rst = 1'b0;
    tick();

    run_op(0, 8, 1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "add_5a_3c");
    run_op(0, 8, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    run_op(0, 8, 1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, "add_7f_00_c");
    run_op(0, 8, 1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0, "sub_10_20");
    run_op(0, 8, 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, "sub_80_01");
    run_op(0, 8, 1'b1, 8'h05, 8'h03, 1'b1, 8'h01, 1'b1, 1'b0, "sub_05_03_b");
    run_op(1, 2, 1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "d4_ff_ff_c");
    run_op(2, 1, 1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "d8_ff_ff_c");
    run_op(1, 2, 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, "d4_sub_80_01");

    // Held start_valid: operand changes after acceptance must not matter
    sub_i = 1'b0; cin_i = 1'b0; a_i = 8'h01; b_i = 8'h01; sv[0] = 1'b1;
    tick();
    a_i = 8'hAA; b_i = 8'h55;
    for (int k = 1; k < 8; k++) tick();
    tick();
    check("seq done1", 32'(done_w[0]), 32'd1);
    check("seq sum1", 32'(sum_w[0]), 32'h02);
    tick();
    check("seq ready_idle", 32'(ready_w[0]), 32'd1);
    check("seq sum_hold", 32'(sum_w[0]), 32'h02);
    tick();
    sv[0] = 1'b0;
    check("seq busy2", 32'(busy_w[0]), 32'd1);
    for (int k = 1; k < 8; k++) tick();
    tick();
    check("seq done2", 32'(done_w[0]), 32'd1);
    check("seq sum2", 32'(sum_w[0]), 32'hFF);
    $display("op seq: second result sum=%02h", sum_w[0]);
    tick();

    // Asynchronous reset mid-operation
    sub_i = 1'b0; cin_i = 1'b0; a_i = 8'h5A; b_i = 8'h3C; sv[0] = 1'b1;
    tick();
    sv[0] = 1'b0;
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst sum", 32'(sum_w[0]), 32'd0);
    check("arst cout", 32'(cout_w[0]), 32'd0);
    check("arst ovf", 32'(ovf_w[0]), 32'd0);
    check("arst busy", 32'(busy_w[0]), 32'd0);
    check("arst ready", 32'(ready_w[0]), 32'd1);
    #1;
    rst = 1'b0;
    begin
      int seen = 0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (done_w[0] === 1'b1) seen++;
      end
      check("arst no_done", 32'(seen), 32'd0);
    end
    $display("op arst: reset mid-run, sum=%02h", sum_w[0]);
    run_op(0, 8, 1'b0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "post_rst_add");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/serial_adder_pw.md
Name: serial_adder_pw

Overview:
- Parametrised, multi-cycle ripple adder/subtractor.
- Accepts two WIDTH-bit operands and a carry-in on a valid/ready handshake.
- Processes DIGIT bits per clock through an internal DIGIT-bit full-adder chain and a registered carry.
- Reports sum, carry-out and signed overflow with a one-cycle done pulse.
- Successor to the team's single-bit gate-level full adder; sits in the arithmetic library for area-constrained datapaths.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT, minimum 2.
- DIGIT, 1, bits added per clock cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  request to start an operation.
- start_ready  output  1  block idle; request accepted on the edge where start_valid and start_ready are both 1.
- sub  input  1  0 = add, 1 = subtract; sampled at acceptance.
- a  input  WIDTH  operand A; sampled at acceptance.
- b  input  WIDTH  operand B; sampled at acceptance.
- cin  input  1  carry-in (add) or borrow-in (sub); sampled at acceptance.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB; in sub mode 1 = no borrow.
- ovf  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when results are valid.

Behaviour:
- Reset (async, rst=1): state IDLE, sum=0, cout=0, ovf=0, busy=0, done=0, start_ready=1, digit counter=0, operand/carry registers=0.
- Arithmetic:
  - add: sum = a + b + cin, taken modulo 2^WIDTH.
  - sub: operand register loads ~b and the carry register loads ~cin, so sum = a - b - cin.
  - cout is the raw carry out of the final digit.
- FSM, 3 states:
  - IDLE: start_ready=1, busy=0. On handshake: latch a, b (inverted if sub) and the carry-in; clear the counter; go to RUN.
  - RUN: start_ready=0, busy=1.
    - Each edge: add the DIGIT LSBs of the A/B shift registers plus the carry register; shift the DIGIT result bits into sum from the MSB end; store the digit carry-out; shift the operands right by DIGIT; increment the counter.
    - On the edge completing digit N-1 (N = WIDTH/DIGIT): capture ovf from the carry into the MSB inside that digit; load cout; go to DONE.
  - DONE: done=1, busy=0, start_ready=0 for exactly one cycle, then IDLE.
- Latency:
  - Acceptance edge E0; digits computed at edges E1..EN; done high in the cycle after EN.
  - Throughput: one operation per N+2 cycles.
- Output holding:
  - sum/cout/ovf remain stable from done until the next acceptance edge.
  - During RUN, sum holds the partial shift value and is not valid.
- start_valid while busy or in DONE is ignored; nothing is queued.
- Input changes after acceptance have no effect on the running operation.
- DIGIT == WIDTH: a single RUN cycle, so done occurs 2 cycles after acceptance.
- Reset asserted mid-RUN or in DONE: immediate return to reset values; the partial result is discarded and done is not pulsed.

Test Plan:
1. WIDTH=8, DIGIT=1, add, a=0x5A b=0x3C cin=0 -> after 9 cycles done=1 for one cycle; sum=0x96 cout=0 ovf=1; start_ready=0 during the operation, 1 the cycle after done.
2. WIDTH=8, DIGIT=1, add, a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1 ovf=0. Then add a=0x7F b=0x00 cin=1 -> sum=0x80 cout=0 ovf=1.
3. WIDTH=8, DIGIT=1, sub:
   - a=0x10 b=0x20 cin=0 -> sum=0xF0 cout=0 ovf=0.
   - a=0x80 b=0x01 cin=0 -> sum=0x7F cout=1 ovf=1.
   - a=0x05 b=0x03 cin=1 -> sum=0x01 cout=1 ovf=0.
4. WIDTH=8, DIGIT=4, add, a=0xFF b=0xFF cin=1 -> sum=0xFF cout=1 ovf=0; done 3 cycles after acceptance. Same operands with DIGIT=8 -> done 2 cycles after acceptance.
5. Sequencing: start_valid held high with a=0x01 b=0x01; change a/b to 0xAA/0x55 on the cycle after acceptance -> first result sum=0x02. A second handshake is accepted only after done; it yields 0xFF.
6. Reset mid-op: accept a=0x5A b=0x3C, assert rst asynchronously (between edges) 3 cycles later -> all outputs 0 and start_ready=1 immediately; no done pulse. A following add 0x01+0x02 -> sum=0x03.
